// File: rtl/ones_count_pkg.sv
// ============================================================================
// Module : ones_count_pkg
// Brief  : Shared constants and width helper for the ones-count block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ones_count_pkg;

  localparam int DEFAULT_N = 3;

  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// Module : full_adder_cell
// Brief  : 3-input full adder; carry is the majority term, sum the 3-way XOR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Two-level product-term form of the majority function.
  assign carry = (a & b) | (a & cin) | (b & cin);
  assign sum   = a ^ b ^ cin;

endmodule

`default_nettype wire

// File: rtl/ones_count_reg.sv
// ============================================================================
// Module : ones_count_reg
// Brief  : Population count of N bits, combinational and registered.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ones_count_reg
  import ones_count_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = popcount_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  din,
  output logic [CW-1:0] count_comb,
  output logic [CW-1:0] count_q,
  output logic          count_q_valid,
  output logic          all_ones,
  output logic          none
);

  localparam int G = (N + 2) / 3;

  logic [3*G-1:0] din_pad;
  logic [G-1:0]   sum_w;
  logic [G-1:0]   carry_w;

  logic [CW-1:0]  count_d;
  logic           valid_d;
  logic           all_ones_d;
  logic           none_d;

  always_comb begin
    din_pad        = '0;
    din_pad[N-1:0] = din;
  end

  // Each cell reduces a group of three bits to a 2-bit weight; N=3 is one cell.
  generate
    for (genvar g = 0; g < G; g++) begin : g_fa
      full_adder_cell u_fa (
        .a     (din_pad[3*g+2]),
        .b     (din_pad[3*g+1]),
        .cin   (din_pad[3*g]),
        .sum   (sum_w[g]),
        .carry (carry_w[g])
      );
    end
  endgenerate

  always_comb begin
    count_comb = '0;
    for (int g = 0; g < G; g++) begin
      count_comb = count_comb + CW'({carry_w[g], sum_w[g]});
    end
  end

  always_comb begin
    count_d    = count_q;
    valid_d    = count_q_valid;
    all_ones_d = all_ones;
    none_d     = none;
    if (en) begin
      count_d    = count_comb;
      valid_d    = 1'b1;
      all_ones_d = (count_comb == CW'(N));
      none_d     = (count_comb == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      count_q_valid <= 1'b0;
      all_ones      <= 1'b0;
      none          <= 1'b0;
    end else begin
      count_q       <= count_d;
      count_q_valid <= valid_d;
      all_ones      <= all_ones_d;
      none          <= none_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ones_count_reg.sv
// ============================================================================
// Module : tb_ones_count_reg
// Brief  : Self-checking bench for ones_count_reg (N=3 and N=5 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ones_count_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] din;
  logic [1:0] count_comb;
  logic [1:0] count_q;
  logic       count_q_valid;
  logic       all_ones;
  logic       none;

  logic       en5;
  logic [4:0] din5;
  logic [2:0] count_comb5;
  logic [2:0] count_q5;
  logic       count_q_valid5;
  logic       all_ones5;
  logic       none5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] din;
    logic [1:0] exp_cnt;
    logic       exp_all;
    logic       exp_none;
  } vec_t;

  typedef struct {
    logic [1:0] cnt;
    logic       valid;
    logic       all;
    logic       nn;
  } exp_t;

  vec_t tbl [9];
  exp_t sb [$];

  ones_count_reg #(.N(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .din           (din),
    .count_comb    (count_comb),
    .count_q       (count_q),
    .count_q_valid (count_q_valid),
    .all_ones      (all_ones),
    .none          (none)
  );

  ones_count_reg #(.N(5)) dut5 (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en5),
    .din           (din5),
    .count_comb    (count_comb5),
    .count_q       (count_q5),
    .count_q_valid (count_q_valid5),
    .all_ones      (all_ones5),
    .none          (none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_and_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h expected entry", nm, count_q);
    end else begin
      e = sb.pop_front();
      chk({nm, ".count_q"}, 32'(count_q), 32'(e.cnt));
      chk({nm, ".valid"}, 32'(count_q_valid), 32'(e.valid));
      chk({nm, ".all_ones"}, 32'(all_ones), 32'(e.all));
      chk({nm, ".none"}, 32'(none), 32'(e.nn));
    end
  endtask

  initial begin
    tbl[0] = '{3'b000, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{3'b100, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{3'b110, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{3'b111, 2'd3, 1'b1, 1'b0};
    tbl[4] = '{3'b011, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{3'b001, 2'd1, 1'b0, 1'b0};
    tbl[6] = '{3'b000, 2'd0, 1'b0, 1'b1};
    tbl[7] = '{3'b101, 2'd2, 1'b0, 1'b0};
    tbl[8] = '{3'b010, 2'd1, 1'b0, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    din   = 3'b111;
    en5   = 1'b0;
    din5  = 5'b0;

    // Reset held across capture edges with en=1 must keep registers cleared.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst.count_q", 32'(count_q), 32'd0);
      chk("rst.valid", 32'(count_q_valid), 32'd0);
      chk("rst.all_ones", 32'(all_ones), 32'd0);
      chk("rst.none", 32'(none), 32'd0);
      chk("rst.count_comb", 32'(count_comb), 32'd3);
    end

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      repeat (3) begin
        @(negedge clk);
        din = tbl[i].din;
        en  = 1'b1;
        #1;
        chk("seq.count_comb", 32'(count_comb), 32'(tbl[i].exp_cnt));
        sb.push_back('{tbl[i].exp_cnt, 1'b1, tbl[i].exp_all, tbl[i].exp_none});
        @(posedge clk);
        #1;
        pop_and_check("seq");
      end
    end

    // Combinational sweep between edges, enable off.
    @(negedge clk);
    en = 1'b0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv  = 3'(v);
      din = vv;
      #0.5;
      chk("comb.sweep", 32'(count_comb), 32'($countones(vv)));
    end

    // Capture 111 then hold with en=0 while din moves to 000.
    @(negedge clk);
    din = 3'b111;
    en  = 1'b1;
    sb.push_back('{2'd3, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    pop_and_check("hold.cap");
    @(negedge clk);
    en  = 1'b0;
    din = 3'b000;
    repeat (5) begin
      sb.push_back('{2'd3, 1'b1, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      pop_and_check("hold");
      chk("hold.count_comb", 32'(count_comb), 32'd0);
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count_q", 32'(count_q), 32'd0);
    chk("arst.valid", 32'(count_q_valid), 32'd0);
    chk("arst.all_ones", 32'(all_ones), 32'd0);
    chk("arst.none", 32'(none), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 3'b010;
    en    = 1'b1;
    #1;
    chk("arst.pre_valid", 32'(count_q_valid), 32'd0);
    sb.push_back('{2'd1, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    pop_and_check("arst.first");

    // Wider instance.
    @(negedge clk);
    din5 = 5'b10111;
    #1;
    chk("n5.count_comb", 32'(count_comb5), 32'd4);
    chk("n5.pre_valid", 32'(count_q_valid5), 32'd0);
    @(negedge clk);
    din5 = 5'b11111;
    en5  = 1'b1;
    #1;
    chk("n5.count_comb_max", 32'(count_comb5), 32'd5);
    @(posedge clk);
    #1;
    chk("n5.count_q", 32'(count_q5), 32'd5);
    chk("n5.all_ones", 32'(all_ones5), 32'd1);
    chk("n5.none", 32'(none5), 32'd0);
    chk("n5.valid", 32'(count_q_valid5), 32'd1);
    @(negedge clk);
    din5 = 5'b00000;
    @(posedge clk);
    #1;
    chk("n5.zero_q", 32'(count_q5), 32'd0);
    chk("n5.zero_none", 32'(none5), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ones_count_reg.md
Name: ones_count_reg

Overview:
- Counts how many of N input bits are high (population count) and presents the result as a binary number.
- With N=3 the 2-bit result is {majority(a,b,c), a^b^c}, i.e. the carry/sum pair of a full adder.
- Provides a combinational result and a registered result.
- Used as a basic gate-structure building block: a two-gate-level reference (wired-AND / open-collector style product terms) plus a clocked capture stage.

Parameters:
- N, 3, number of input bits (legal range 1..16).
- CW, $clog2(N+1), width of the count output (derived; not overridden by users).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable for the registered count.
- din  input  N  bits to be counted; for N=3, din[2]=a, din[1]=b, din[0]=c.
- count_comb  output  CW  combinational popcount of din.
- count_q  output  CW  registered popcount.
- count_q_valid  output  1  high once count_q holds a captured value.
- all_ones  output  1  registered; high when the captured count equals N.
- none  output  1  registered; high when the captured count equals 0.

Behaviour:
- count_comb = number of 1 bits in din.
  - Purely combinational, zero latency, no dependence on clk or rst_n.
  - For N=3: count_comb[1] = a&b | a&c | b&c and count_comb[0] = a^b^c.
- Reset: while rst_n=0, count_q=0, count_q_valid=0, all_ones=0, none=0.
  - Reset takes effect immediately, with no clock edge needed.
  - Release of rst_n is sampled synchronously; the first capture can happen on the first rising edge after rst_n goes high.
- Capture: on a rising clk edge with rst_n=1 and en=1:
  - count_q <= count_comb (one-cycle latency from din to count_q).
  - count_q_valid <= 1.
  - all_ones <= (count_comb == N).
  - none <= (count_comb == 0).
- With en=0, all registered outputs hold their values.
- count_q_valid stays 1 until the next reset.
- Reset asserted mid-operation overrides any capture in the same cycle.
- Arithmetic:
  - The count is unsigned.
  - Maximum value N always fits in CW bits; no overflow or saturation is possible.
- X on din propagates to count_comb. Registered outputs capture X only when en=1.

Decomposition:
- Shared package (ones_count_pkg):
  - function popcount_width(n) returning $clog2(n+1).
  - Constant DEFAULT_N = 3.
- Sub-module full_adder_cell (a, b, cin -> sum, carry).
  - carry is the majority term; sum is the 3-input XOR.
  - Instantiated in a generate-built adder tree that forms count_comb for general N.
  - For N=3 the tree is a single cell.

Test Plan:
- Reset: hold rst_n=0 with din=3'b111, en=1 for 3 clocks -> count_q=0, count_q_valid=0, all_ones=0, none=0; count_comb=2'b11.
- Sequence, with en=1, holding each din value several cycles; one clock after each change count_q follows:
  - din 000 -> 00
  - din 100 -> 01
  - din 110 -> 10
  - din 111 -> 11 (all_ones=1)
  - din 011 -> 10
  - din 001 -> 01
  - din 000 -> 00 (none=1)
- Combinational check: sweep all 8 din values without a clock -> count_comb equals popcount immediately, e.g. 101->10 and 010->01.
- Enable hold: capture din=111, then set en=0 and din=000 for 5 clocks -> count_q stays 11 and all_ones stays 1 while count_comb=00.
- Async reset mid-stream: assert rst_n=0 between clock edges while count_q=11 -> all registered outputs go to 0 before the next edge; after release, the first edge with en=1 and din=010 gives count_q=01 and count_q_valid=1.
- Parameter N=5: din=5'b10111 -> count_comb=3'b100 (4); din=5'b11111 -> count_q=5 and all_ones=1 after one clock.
